gray_step_tracker: RTL and testbench

Downstream consumer of the 4-bit binary-to-Gray converter output, for example a Gray-coded position sensor or a counter bus that crosses domains. It registers each valid 4-bit Gray sample and decodes it back to binary. It compares each decoded value with the previous one and classifies the transition as up-step, down-step, hold or illegal jump. It maintains a wrapping signed position counter and a fault state that holds until software requests a resync.

---
 rtl/gray_pkg.sv | 15 +
 rtl/gray_step_tracker_if.sv | 26 ++
 rtl/gray_to_bin_4.sv | 11 +
 rtl/gray_step_tracker.sv | 114 +++++++++++
 tb/tb_gray_step_tracker.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared encodings for the Gray-sample step tracker: FSM states and legal step deltas.
// Pure constants, no logic.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam logic [3:0] DELTA_HOLD = 4'd0;
    localparam logic [3:0] DELTA_UP   = 4'd1;
    localparam logic [3:0] DELTA_DN   = 4'd15;

endpackage

// File: rtl/gray_step_tracker_if.sv
// Sample/control bundle between a Gray sample source (master) and the tracker (slave).
// No flow control: the tracker accepts one sample per cycle and never stalls the source.
interface gray_step_tracker_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       gray_in;
    logic             in_valid;
    logic             resync;
    logic [3:0]       bin_out;
    logic             step_up;
    logic             step_down;
    logic             step_err;
    logic             dir;
    logic [CNT_W-1:0] pos_count;
    logic             locked;

    modport master (
        output gray_in, in_valid, resync,
        input  bin_out, step_up, step_down, step_err, dir, pos_count, locked
    );

    modport slave (
        input  gray_in, in_valid, resync,
        output bin_out, step_up, step_down, step_err, dir, pos_count, locked
    );
endinterface

// File: rtl/gray_to_bin_4.sv
// Combinational 4-bit Gray-to-binary decoder, inverse of the binary-to-Gray converter.
// Zero latency, no backpressure.
module gray_to_bin_4 (
    input  logic [3:0] gray_i,
    output logic [3:0] bin_o
);
    assign bin_o[3] = gray_i[3];
    assign bin_o[2] = bin_o[3] ^ gray_i[2];
    assign bin_o[1] = bin_o[2] ^ gray_i[1];
    assign bin_o[0] = bin_o[1] ^ gray_i[0];
endmodule

// File: rtl/gray_step_tracker.sv
// Tracks a Gray-coded position stream: classifies each sample as step up/down/hold/illegal.
// Latency 2 cycles from in_valid to outputs; one sample per cycle, never backpressures.
module gray_step_tracker
    import gray_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    gray_step_tracker_if.slave bus
);
    logic [3:0]       gray_q;
    logic             vld_q;
    state_e           state_q, state_d;
    // bin_out doubles as prev_bin: both are loaded with every decoded valid sample.
    logic [3:0]       bin_q, bin_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;
    logic             err_q, err_d;
    logic             locked_q;

    logic [3:0]       cur_bin;
    logic [3:0]       delta;

    gray_to_bin_4 u_dec (
        .gray_i (gray_q),
        .bin_o  (cur_bin)
    );

    assign delta = cur_bin - bin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q   <= 4'd0;
            vld_q    <= 1'b0;
            state_q  <= IDLE;
            bin_q    <= 4'd0;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            gray_q   <= bus.gray_in;
            vld_q    <= bus.in_valid & ~bus.resync;
            state_q  <= state_d;
            bin_q    <= bin_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            err_q    <= err_d;
            locked_q <= (state_d == TRACK);
        end
    end

    always_comb begin
        state_d = state_q;
        if (vld_q) begin
            case (state_q)
                IDLE:  state_d = TRACK;
                TRACK: begin
                    if (delta != DELTA_HOLD && delta != DELTA_UP && delta != DELTA_DN)
                        state_d = FAULT;
                end
                FAULT: state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
        // resync overrides everything, including a jump being flagged this cycle
        if (bus.resync)
            state_d = IDLE;
    end

    always_comb begin
        bin_d = bin_q;
        pos_d = pos_q;
        dir_d = dir_q;
        up_d  = 1'b0;
        dn_d  = 1'b0;
        err_d = 1'b0;
        if (vld_q) begin
            bin_d = cur_bin;
            if (state_q == TRACK) begin
                case (delta)
                    DELTA_HOLD: ;
                    DELTA_UP: begin
                        up_d  = 1'b1;
                        pos_d = pos_q + CNT_W'(1);
                        dir_d = 1'b1;
                    end
                    DELTA_DN: begin
                        dn_d  = 1'b1;
                        pos_d = pos_q - CNT_W'(1);
                        dir_d = 1'b0;
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    assign bus.bin_out   = bin_q;
    assign bus.step_up   = up_q;
    assign bus.step_down = dn_q;
    assign bus.step_err  = err_q;
    assign bus.dir       = dir_q;
    assign bus.pos_count = pos_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_gray_step_tracker.sv
// Bench for gray_step_tracker: cycle model feeds a scoreboard queue, scenario tasks check end states.
module tb_gray_step_tracker;
    localparam int CNT_W = 8;
    localparam logic [1:0] M_IDLE = 2'd0, M_TRACK = 2'd1, M_FAULT = 2'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_step_tracker_if #(.CNT_W(CNT_W)) bus ();

    gray_step_tracker #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]       bin;
        logic             up;
        logic             dn;
        logic             err;
        logic             dir;
        logic [CNT_W-1:0] pos;
        logic             locked;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_up = 0, n_dn = 0, n_err = 0;

    logic [1:0]       m_state;
    logic [3:0]       m_bin, ma_g;
    logic             ma_v, m_dir;
    logic [CNT_W-1:0] m_pos;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] from_gray(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Drive one clock of stimulus; push what the outputs must be right after this edge.
    task automatic cycle(input logic [3:0] g, input logic v, input logic r, input logic rs);
        exp_t e;
        logic [3:0] cur, delta;
        logic [1:0] nxt;
        rst = rs; bus.gray_in = g; bus.in_valid = v; bus.resync = r;
        e = '0;
        if (rs) begin
            m_state = M_IDLE; m_bin = 4'd0; m_pos = '0; m_dir = 1'b1;
            ma_g = 4'd0; ma_v = 1'b0;
        end else begin
            nxt = m_state;
            if (ma_v) begin
                cur   = from_gray(ma_g);
                delta = cur - m_bin;
                if (m_state == M_IDLE) nxt = M_TRACK;
                else if (m_state == M_TRACK) begin
                    if (delta == 4'd1) begin e.up = 1'b1; m_pos = m_pos + 1'b1; m_dir = 1'b1; end
                    else if (delta == 4'd15) begin e.dn = 1'b1; m_pos = m_pos - 1'b1; m_dir = 1'b0; end
                    else if (delta != 4'd0) begin e.err = 1'b1; nxt = M_FAULT; end
                end
                m_bin = cur;
            end
            if (r) nxt = M_IDLE;
            m_state = nxt;
            ma_g = g;
            ma_v = v & ~r;
        end
        e.bin = m_bin; e.dir = m_dir; e.pos = m_pos; e.locked = (m_state == M_TRACK);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.step_up === 1'b1)   n_up++;
        if (bus.step_down === 1'b1) n_dn++;
        if (bus.step_err === 1'b1)  n_err++;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks += 7;
            if (bus.bin_out !== mon_e.bin) begin n_errors++; $display("FAIL sb_bin_out t=%0t got=%h exp=%h", $time, bus.bin_out, mon_e.bin); end
            if (bus.step_up !== mon_e.up) begin n_errors++; $display("FAIL sb_step_up t=%0t got=%b exp=%b", $time, bus.step_up, mon_e.up); end
            if (bus.step_down !== mon_e.dn) begin n_errors++; $display("FAIL sb_step_down t=%0t got=%b exp=%b", $time, bus.step_down, mon_e.dn); end
            if (bus.step_err !== mon_e.err) begin n_errors++; $display("FAIL sb_step_err t=%0t got=%b exp=%b", $time, bus.step_err, mon_e.err); end
            if (bus.dir !== mon_e.dir) begin n_errors++; $display("FAIL sb_dir t=%0t got=%b exp=%b", $time, bus.dir, mon_e.dir); end
            if (bus.pos_count !== mon_e.pos) begin n_errors++; $display("FAIL sb_pos_count t=%0t got=%h exp=%h", $time, bus.pos_count, mon_e.pos); end
            if (bus.locked !== mon_e.locked) begin n_errors++; $display("FAIL sb_locked t=%0t got=%b exp=%b", $time, bus.locked, mon_e.locked); end
        end
    end

    task automatic do_reset();
        cycle(4'd0, 1'b0, 1'b0, 1'b1);
        cycle(4'd0, 1'b0, 1'b0, 1'b1);
        n_up = 0; n_dn = 0; n_err = 0;
    endtask

    task automatic test_reset();
        cycle(4'd0, 1'b0, 1'b0, 1'b1);
        cycle(4'd0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus.bin_out !== 4'd0 || bus.pos_count !== 8'h00 || bus.dir !== 1'b1 || bus.locked !== 1'b0 ||
            bus.step_up !== 1'b0 || bus.step_down !== 1'b0 || bus.step_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values got bin=%h pos=%h dir=%b lck=%b up=%b dn=%b err=%b exp 0/00/1/0/0/0/0",
                     bus.bin_out, bus.pos_count, bus.dir, bus.locked, bus.step_up, bus.step_down, bus.step_err);
        end
        n_up = 0; n_dn = 0; n_err = 0;
    endtask

    task automatic test_first_sample();
        cycle(4'b0110, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.bin_out !== 4'b0100 || bus.locked !== 1'b1 || bus.pos_count !== 8'h00 || (n_up + n_dn + n_err) != 0) begin
            n_errors++;
            $display("FAIL first_sample got bin=%b lck=%b pos=%h pulses=%0d exp bin=0100 lck=1 pos=00 pulses=0",
                     bus.bin_out, bus.locked, bus.pos_count, n_up + n_dn + n_err);
        end
    endtask

    task automatic test_up_sweep();
        do_reset();
        for (int i = 0; i < 16; i++) cycle(to_gray(4'(i)), 1'b1, 1'b0, 1'b0);
        cycle(to_gray(4'd0), 1'b1, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (n_up != 16 || n_dn != 0 || n_err != 0 || bus.pos_count !== 8'd16 || bus.dir !== 1'b1 || bus.bin_out !== 4'd0) begin
            n_errors++;
            $display("FAIL up_sweep got up=%0d dn=%0d err=%0d pos=%h dir=%b bin=%h exp up=16 dn=0 err=0 pos=10 dir=1 bin=0",
                     n_up, n_dn, n_err, bus.pos_count, bus.dir, bus.bin_out);
        end
    endtask

    task automatic test_down_steps();
        do_reset();
        cycle(to_gray(4'd2), 1'b1, 1'b0, 1'b0);
        cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (n_dn != 3 || n_up != 0 || n_err != 0 || bus.pos_count !== 8'hFD || bus.dir !== 1'b0 || bus.bin_out !== 4'd15) begin
            n_errors++;
            $display("FAIL down_steps got dn=%0d up=%0d err=%0d pos=%h dir=%b bin=%h exp dn=3 up=0 err=0 pos=fd dir=0 bin=f",
                     n_dn, n_up, n_err, bus.pos_count, bus.dir, bus.bin_out);
        end
    endtask

    task automatic test_illegal_jump();
        do_reset();
        cycle(to_gray(4'd3), 1'b1, 1'b0, 1'b0);
        cycle(4'b0101, 1'b1, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (n_err != 1 || bus.locked !== 1'b0 || bus.pos_count !== 8'h00 || bus.bin_out !== 4'd6) begin
            n_errors++;
            $display("FAIL illegal_jump got err=%0d lck=%b pos=%h bin=%h exp err=1 lck=0 pos=00 bin=6",
                     n_err, bus.locked, bus.pos_count, bus.bin_out);
        end
        n_up = 0; n_dn = 0; n_err = 0;
        cycle(to_gray(4'd7), 1'b1, 1'b0, 1'b0);
        cycle(to_gray(4'd8), 1'b1, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ((n_up + n_dn + n_err) != 0 || bus.locked !== 1'b0 || bus.bin_out !== 4'd8) begin
            n_errors++;
            $display("FAIL fault_hold got pulses=%0d lck=%b bin=%h exp pulses=0 lck=0 bin=8",
                     n_up + n_dn + n_err, bus.locked, bus.bin_out);
        end
        cycle(4'd0, 1'b0, 1'b1, 1'b0);
        cycle(to_gray(4'd12), 1'b1, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ((n_up + n_dn + n_err) != 0 || bus.locked !== 1'b1 || bus.bin_out !== 4'd12) begin
            n_errors++;
            $display("FAIL relock got pulses=%0d lck=%b bin=%h exp pulses=0 lck=1 bin=c",
                     n_up + n_dn + n_err, bus.locked, bus.bin_out);
        end
    endtask

    task automatic test_hold_wrap_collision();
        logic [3:0] b;
        do_reset();
        b = 4'd0;
        cycle(to_gray(b), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 127; k++) begin
            b = b + 4'd1;
            cycle(to_gray(b), 1'b1, 1'b0, 1'b0);
            if (k % 9 == 0) begin
                cycle(to_gray(b), 1'b1, 1'b0, 1'b0);
                cycle(4'b1010, 1'b0, 1'b0, 1'b0);
            end
        end
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (n_up != 127 || n_dn != 0 || n_err != 0 || bus.pos_count !== 8'h7F) begin
            n_errors++;
            $display("FAIL hold_gaps got up=%0d dn=%0d err=%0d pos=%h exp up=127 dn=0 err=0 pos=7f",
                     n_up, n_dn, n_err, bus.pos_count);
        end
        b = b + 4'd1;
        cycle(to_gray(b), 1'b1, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.pos_count !== 8'h80 || n_up != 128) begin
            n_errors++;
            $display("FAIL wrap_7f_80 got pos=%h up=%0d exp pos=80 up=128", bus.pos_count, n_up);
        end
        cycle(to_gray(b + 4'd1), 1'b1, 1'b1, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.locked !== 1'b0 || bus.bin_out !== b || n_up != 128 || bus.pos_count !== 8'h80) begin
            n_errors++;
            $display("FAIL collision_drop got lck=%b bin=%h up=%0d pos=%h exp lck=0 bin=%h up=128 pos=80",
                     bus.locked, bus.bin_out, n_up, bus.pos_count, b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(to_gray(4'd4), 1'b1, 1'b0, 1'b0);
        cycle(to_gray(4'd5), 1'b1, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (bus.bin_out !== 4'd0 || bus.pos_count !== 8'h00 || bus.dir !== 1'b1 || bus.locked !== 1'b0 || n_up != 0) begin
            n_errors++;
            $display("FAIL reset_mid got bin=%h pos=%h dir=%b lck=%b up=%0d exp bin=0 pos=00 dir=1 lck=0 up=0",
                     bus.bin_out, bus.pos_count, bus.dir, bus.locked, n_up);
        end
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ((n_up + n_dn + n_err) != 0 || bus.locked !== 1'b0 || bus.bin_out !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_mid_discard got pulses=%0d lck=%b bin=%h exp pulses=0 lck=0 bin=0",
                     n_up + n_dn + n_err, bus.locked, bus.bin_out);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.gray_in = 4'd0;
        bus.in_valid = 1'b0;
        bus.resync = 1'b0;
        test_reset();
        test_first_sample();
        test_up_sweep();
        test_down_steps();
        test_illegal_jump();
        test_hold_wrap_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
